// File: rtl/tdm_pkg.sv
// rtl/tdm_pkg.sv - shared constants, state type and slot decode for the TDM demux
package tdm_pkg;

    localparam int NUM_CH = 4;
    localparam int SLOT_W = 2;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Slot index to one-hot channel strobe
    function automatic logic [NUM_CH-1:0] onehot4(input logic [SLOT_W-1:0] s);
        logic [NUM_CH-1:0] r;
        r    = '0;
        r[s] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter that sticks at all-ones
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    // Count increments, holding at the maximum value instead of wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/tdm_demux4.sv
// rtl/tdm_demux4.sv - registered 1-to-4 TDM demultiplexer with sync tracking
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int ERR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  din,
    input  logic              din_valid,
    input  logic              sync,
    output logic [WIDTH-1:0]  c0,
    output logic [WIDTH-1:0]  c1,
    output logic [WIDTH-1:0]  c2,
    output logic [WIDTH-1:0]  c3,
    output logic [NUM_CH-1:0] strobe,
    output logic              frame_done,
    output logic [SLOT_W-1:0] slot,
    output logic              locked,
    output logic              sync_err,
    output logic [ERR_W-1:0]  err_cnt
);

    state_t           state;
    logic [WIDTH-1:0] ch [NUM_CH];
    logic             misalign;

    // A sync marker seen while locked but not at slot 0 abandons the partial frame
    assign misalign = din_valid && sync && (state == LOCKED) && (slot != '0);

    assign c0     = ch[0];
    assign c1     = ch[1];
    assign c2     = ch[2];
    assign c3     = ch[3];
    assign locked = (state == LOCKED);

    // Frame tracking FSM: hunts for sync, then steers each valid word to its slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= HUNT;
            slot       <= '0;
            strobe     <= '0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                ch[i] <= '0;
            end
        end else begin
            strobe     <= '0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
            if (din_valid) begin
                case (state)
                    HUNT: begin
                        if (sync) begin
                            ch[0]  <= din;
                            strobe <= onehot4(SLOT_W'(0));
                            slot   <= SLOT_W'(1);
                            state  <= LOCKED;
                        end
                    end
                    LOCKED: begin
                        if (misalign) begin
                            ch[0]    <= din;
                            strobe   <= onehot4(SLOT_W'(0));
                            slot     <= SLOT_W'(1);
                            sync_err <= 1'b1;
                        end else begin
                            ch[slot]   <= din;
                            strobe     <= onehot4(slot);
                            slot       <= slot + SLOT_W'(1);
                            frame_done <= (slot == SLOT_W'(NUM_CH - 1));
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

    sat_counter #(
        .W(ERR_W)
    ) u_err_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (misalign),
        .cnt  (err_cnt)
    );

endmodule

// File: tb/tb_tdm_demux4.sv
// tb/tb_tdm_demux4.sv - self-checking bench for tdm_demux4
module tb_tdm_demux4;

    localparam int WIDTH   = 8;
    localparam int ERR_W   = 8;
    localparam int ERR_MAX = (1 << ERR_W) - 1;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             sync;
    logic [WIDTH-1:0] c0, c1, c2, c3;
    logic [3:0]       strobe;
    logic             frame_done;
    logic [1:0]       slot;
    logic             locked;
    logic             sync_err;
    logic [ERR_W-1:0] err_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state, kept as plain integers
    int m_ch [4];
    int m_strobe, m_fd, m_serr, m_slot, m_locked, m_err;

    tdm_demux4 #(.WIDTH(WIDTH), .ERR_W(ERR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .din_valid (din_valid),
        .sync      (sync),
        .c0        (c0),
        .c1        (c1),
        .c2        (c2),
        .c3        (c3),
        .strobe    (strobe),
        .frame_done(frame_done),
        .slot      (slot),
        .locked    (locked),
        .sync_err  (sync_err),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         rst;
        bit         v;
        bit         s;
        logic [7:0] d;
        logic [3:0] exp_strobe;
        bit         exp_fd;
        bit         exp_serr;
        logic [1:0] exp_slot;
        bit         exp_locked;
    } vec_t;

    vec_t tbl [11];

    function automatic vec_t mk(bit rst, bit v, bit s, logic [7:0] d, logic [3:0] st,
                                bit fd, bit se, logic [1:0] sl, bit lk);
        vec_t r;
        r.rst = rst; r.v = v; r.s = s; r.d = d;
        r.exp_strobe = st; r.exp_fd = fd; r.exp_serr = se;
        r.exp_slot = sl; r.exp_locked = lk;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_ch[i] = 0;
        m_strobe = 0; m_fd = 0; m_serr = 0; m_slot = 0; m_locked = 0; m_err = 0;
    endtask

    task automatic model_step(input bit v, input bit s, input int d);
        m_strobe = 0; m_fd = 0; m_serr = 0;
        if (v) begin
            if (m_locked == 0) begin
                if (s) begin
                    m_ch[0] = d; m_strobe = 1; m_slot = 1; m_locked = 1;
                end
            end else if (s && m_slot != 0) begin
                m_serr = 1;
                m_err = (m_err < ERR_MAX) ? m_err + 1 : ERR_MAX;
                m_ch[0] = d; m_strobe = 1; m_slot = 1;
            end else begin
                m_ch[m_slot] = d;
                m_strobe = 1 << m_slot;
                m_fd = (m_slot == 3) ? 1 : 0;
                m_slot = (m_slot + 1) % 4;
            end
        end
    endtask

    task automatic compare_model(input string tag);
        chk({tag, " c0"}, 32'(c0), 32'(m_ch[0]));
        chk({tag, " c1"}, 32'(c1), 32'(m_ch[1]));
        chk({tag, " c2"}, 32'(c2), 32'(m_ch[2]));
        chk({tag, " c3"}, 32'(c3), 32'(m_ch[3]));
        chk({tag, " strobe"}, 32'(strobe), 32'(m_strobe));
        chk({tag, " frame_done"}, 32'(frame_done), 32'(m_fd));
        chk({tag, " sync_err"}, 32'(sync_err), 32'(m_serr));
        chk({tag, " slot"}, 32'(slot), 32'(m_slot));
        chk({tag, " locked"}, 32'(locked), 32'(m_locked));
        chk({tag, " err_cnt"}, 32'(err_cnt), 32'(m_err));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " c0"}, 32'(c0), 0);
        chk({tag, " c1"}, 32'(c1), 0);
        chk({tag, " c2"}, 32'(c2), 0);
        chk({tag, " c3"}, 32'(c3), 0);
        chk({tag, " strobe"}, 32'(strobe), 0);
        chk({tag, " frame_done"}, 32'(frame_done), 0);
        chk({tag, " slot"}, 32'(slot), 0);
        chk({tag, " locked"}, 32'(locked), 0);
        chk({tag, " sync_err"}, 32'(sync_err), 0);
        chk({tag, " err_cnt"}, 32'(err_cnt), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; din_valid = 1'b0; sync = 1'b0; din = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        #1;
        check_all_zero("reset");
    endtask

    task automatic step(input bit v, input bit s, input logic [7:0] d, input string tag);
        @(negedge clk);
        din_valid = v; sync = s; din = d;
        @(posedge clk);
        #1;
        model_step(v, s, int'(d));
        compare_model(tag);
    endtask

    initial begin
        rst_n = 1'b1; din_valid = 1'b0; sync = 1'b0; din = '0;
        model_reset();

        // Directed vectors: in-order frame, idle sync, misalignment, hunt behaviour
        tbl[0]  = mk(1, 1, 1, 8'h11, 4'b0001, 0, 0, 2'd1, 1);
        tbl[1]  = mk(0, 1, 0, 8'h22, 4'b0010, 0, 0, 2'd2, 1);
        tbl[2]  = mk(0, 1, 0, 8'h33, 4'b0100, 0, 0, 2'd3, 1);
        tbl[3]  = mk(0, 1, 0, 8'h44, 4'b1000, 1, 0, 2'd0, 1);
        tbl[4]  = mk(0, 0, 1, 8'h77, 4'b0000, 0, 0, 2'd0, 1);
        tbl[5]  = mk(0, 1, 0, 8'h01, 4'b0001, 0, 0, 2'd1, 1);
        tbl[6]  = mk(0, 1, 0, 8'h02, 4'b0010, 0, 0, 2'd2, 1);
        tbl[7]  = mk(0, 1, 1, 8'h03, 4'b0001, 0, 1, 2'd1, 1);
        tbl[8]  = mk(1, 1, 0, 8'hAA, 4'b0000, 0, 0, 2'd0, 0);
        tbl[9]  = mk(0, 1, 0, 8'hBB, 4'b0000, 0, 0, 2'd0, 0);
        tbl[10] = mk(0, 1, 1, 8'hCC, 4'b0001, 0, 0, 2'd1, 1);

        for (int i = 0; i < 11; i++) begin
            if (tbl[i].rst) do_reset();
            step(tbl[i].v, tbl[i].s, tbl[i].d, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d strobe", i), 32'(strobe), 32'(tbl[i].exp_strobe));
            chk($sformatf("vec%0d frame_done", i), 32'(frame_done), 32'(tbl[i].exp_fd));
            chk($sformatf("vec%0d sync_err", i), 32'(sync_err), 32'(tbl[i].exp_serr));
            chk($sformatf("vec%0d slot", i), 32'(slot), 32'(tbl[i].exp_slot));
            chk($sformatf("vec%0d locked", i), 32'(locked), 32'(tbl[i].exp_locked));
            if (i == 3) begin
                chk("frame c0", 32'(c0), 32'h11);
                chk("frame c1", 32'(c1), 32'h22);
                chk("frame c2", 32'(c2), 32'h33);
                chk("frame c3", 32'(c3), 32'h44);
            end
            if (i == 7) begin
                chk("misalign err_cnt", 32'(err_cnt), 1);
                chk("misalign c0", 32'(c0), 32'h03);
                chk("misalign c1", 32'(c1), 32'h02);
                chk("misalign c2", 32'(c2), 32'h33);
                chk("misalign c3", 32'(c3), 32'h44);
            end
            if (i == 10) chk("hunt c0", 32'(c0), 32'hCC);
        end

        // Back-to-back frames with no bubbles, then idle cycles
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            step(1'b1, (k == 1 || k == 5), 8'(8'h30 + k), $sformatf("b2b%0d", k));
            chk($sformatf("b2b%0d frame_done", k), 32'(frame_done), (k == 4 || k == 8) ? 1 : 0);
            chk($sformatf("b2b%0d sync_err", k), 32'(sync_err), 0);
        end
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 8'hEE, $sformatf("idle%0d", k));
            chk($sformatf("idle%0d strobe", k), 32'(strobe), 0);
            chk($sformatf("idle%0d c3", k), 32'(c3), 32'h38);
        end

        // Error counter saturation: one locking sync then 300 misaligned syncs
        do_reset();
        step(1'b1, 1'b1, 8'h00, "sat_lock");
        for (int k = 0; k < 300; k++) step(1'b1, 1'b1, 8'(k), "sat");
        chk("sat err_cnt", 32'(err_cnt), 32'hFF);

        // Asynchronous reset mid-frame, between clock edges
        do_reset();
        step(1'b1, 1'b1, 8'h5A, "ar0");
        step(1'b1, 1'b0, 8'h6B, "ar1");
        chk("ar slot before", 32'(slot), 2);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        #2;
        rst_n = 1'b1;
        model_reset();
        step(1'b1, 1'b0, 8'h99, "post_ar0");
        step(1'b1, 1'b0, 8'h98, "post_ar1");
        chk("post_ar locked", 32'(locked), 0);

        // Randomized traffic against the reference model
        do_reset();
        for (int k = 0; k < 2000; k++) begin
            step(($urandom % 4) != 0, ($urandom % 5) == 0, 8'($urandom), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
- Registered 1-to-4 time-division demultiplexer, the receive-side counterpart of the 4:1 channel mux.
- Takes a serial word stream in which channel slots 0..3 arrive in rotation, with a sync marker on slot 0.
- Distributes each word to one of four held output channels c0..c3.
- Raises per-channel strobes, a frame-complete pulse and sync-error reporting for downstream logic.

Parameters:
- WIDTH, 8, data word width for din and each channel output.
- ERR_W, 8, width of the saturating sync-error counter.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- din  input  WIDTH  incoming TDM data word.
- din_valid  input  1  din is a valid slot word this cycle.
- sync  input  1  qualifies din as slot 0 (frame start); meaningful only with din_valid.
- c0  output  WIDTH  channel 0 held word.
- c1  output  WIDTH  channel 1 held word.
- c2  output  WIDTH  channel 2 held word.
- c3  output  WIDTH  channel 3 held word.
- strobe  output  4  one-hot, bit n pulses for one cycle when cn is updated.
- frame_done  output  1  one-cycle pulse when slot 3 of an in-order frame is written.
- slot  output  2  next expected slot index.
- locked  output  1  high in LOCKED state.
- sync_err  output  1  one-cycle pulse on misaligned sync.
- err_cnt  output  ERR_W  saturating count of sync errors.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (rst_n). Asserting rst_n low clears all state immediately, including mid-frame.
- Reset values: c0..c3=0, strobe=0, frame_done=0, slot=0, locked=0, sync_err=0, err_cnt=0, state=HUNT.
- Timing: all outputs are registered. A word sampled at edge k is visible on cn together with strobe[n] after edge k, i.e. 1-cycle latency. Pulses last exactly one cycle.
- Idle cycles: din_valid=0 updates nothing, and strobe, frame_done and sync_err return to 0. sync without din_valid is ignored.
- State HUNT:
  - din_valid and not sync: word discarded, no strobe.
  - din_valid and sync: c0<=din, strobe=0001, slot<=1, go to LOCKED.
- State LOCKED, din_valid and not sync:
  - c[slot]<=din, strobe=onehot(slot), slot<=slot+1 mod 4 (3 wraps to 0).
  - If slot was 3, frame_done=1 in the same cycle as strobe[3].
- State LOCKED, din_valid and sync:
  - slot==0: normal slot-0 write, identical to the non-sync case.
  - slot!=0: misalignment. sync_err=1, err_cnt<=err_cnt+1 saturating at all-ones, c0<=din, strobe=0001, slot<=1. The partial frame is abandoned: no frame_done, and the other channels hold their old values.
- Missing sync: slot 0 arriving without sync while LOCKED is accepted (free-running). Lock is never dropped except by reset.
- Holding: cn holds its value until overwritten. Back-to-back valid words on every cycle are fully supported with no bubbles.

Decomposition:
- Shared package tdm_pkg:
  - NUM_CH=4 and SLOT_W=2.
  - state enum {HUNT, LOCKED}.
  - onehot4(slot) function.
- Sub-module sat_counter (parameter W; inputs clk, rst_n, inc; output cnt): saturating error counter, instantiated once with W=ERR_W.
- The remainder stays in tdm_demux4.

Test Plan:
- Reset, then send 4 valid words 0x11, 0x22, 0x33, 0x44 with sync on the first -> c0..c3 = 0x11, 0x22, 0x33, 0x44. Strobes in order 0001, 0010, 0100, 1000. frame_done only with strobe 1000. locked=1, slot=0.
- In HUNT, send 0xAA, 0xBB with no sync, then 0xCC with sync -> no strobes for the first two words, then c0=0xCC, strobe=0001, locked=1.
- LOCKED, send 0x01, 0x02 from slot 0, then 0x03 with sync -> sync_err pulses once, err_cnt=1, c0=0x03, c1=0x02, c2 unchanged, no frame_done, slot=1.
- Force 300 misaligned syncs with ERR_W=8 -> err_cnt saturates at 0xFF and does not wrap.
- Two frames back-to-back with din_valid held high for 8 cycles, the second frame with sync -> frame_done pulses on cycles 4 and 8, no sync_err. Then din_valid low for 3 cycles -> strobe=0 and outputs hold.
- Drop rst_n asynchronously between clock edges mid-frame (slot=2) -> all outputs go to 0 immediately with no clock. After release, state=HUNT and words without sync are ignored.
